// File: rtl/audio_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_pkg                                                        |
// | Shared types, constants and arithmetic helpers for the audio     |
// | mixer and delta-sigma modulator.                                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        LOAD = 2'd2
    } mix_state_t;

    localparam logic ORDER1 = 1'b0;
    localparam logic ORDER2 = 1'b1;

    // Wide enough that CHANNELS full-scale samples never wrap.
    function automatic int sum_width(input int width, input int channels);
        return width + $clog2(channels) + 1;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_dsm_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_dsm_core                                                   |
// | First/second-order delta-sigma modulator producing a 1-bit pwm.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module audio_dsm_core
    import audio_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] mix,
    input  logic                    order,
    output logic                    pwm
);

    localparam int c_i1_w = WIDTH + 2;
    localparam int c_i2_w = WIDTH + 4;

    logic                      r_order;
    logic [WIDTH-1:0]          r_acc;
    logic signed [c_i1_w-1:0]  r_i1;
    logic signed [c_i2_w-1:0]  r_i2;
    logic                      r_pwm;

    logic [WIDTH-1:0]          w_x;
    logic [WIDTH:0]            w_acc_sum;
    logic signed [63:0]        w_mix64;
    logic signed [63:0]        w_fb64;
    logic signed [63:0]        w_i1_64;
    logic signed [63:0]        w_i1n_64;
    logic signed [63:0]        w_i2_64;
    logic signed [c_i1_w-1:0]  w_i1_next;
    logic signed [c_i2_w-1:0]  w_i2_next;

    // Offset-binary view of the mix: carry rate equals x / 2^WIDTH.
    assign w_x       = {~mix[WIDTH-1], mix[WIDTH-2:0]};
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_x};

    assign w_mix64   = {{(64-WIDTH){mix[WIDTH-1]}}, mix};
    assign w_fb64    = r_pwm ? (64'sd1 <<< (WIDTH - 1)) : -(64'sd1 <<< (WIDTH - 1));
    assign w_i1_64   = {{(64-c_i1_w){r_i1[c_i1_w-1]}}, r_i1};
    assign w_i2_64   = {{(64-c_i2_w){r_i2[c_i2_w-1]}}, r_i2};
    assign w_i1_next = c_i1_w'(saturate(w_i1_64 + w_mix64 - w_fb64, c_i1_w));
    assign w_i1n_64  = {{(64-c_i1_w){w_i1_next[c_i1_w-1]}}, w_i1_next};
    assign w_i2_next = c_i2_w'(saturate(w_i2_64 + w_i1n_64 - w_fb64, c_i2_w));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_order <= ORDER1;
            r_acc   <= '0;
            r_i1    <= '0;
            r_i2    <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_order <= order;
            if (order != r_order) begin
                r_acc <= '0;
                r_i1  <= '0;
                r_i2  <= '0;
                r_pwm <= 1'b0;
            end else if (order == ORDER2) begin
                r_i1  <= w_i1_next;
                r_i2  <= w_i2_next;
                r_pwm <= ~w_i2_next[c_i2_w-1];
            end else begin
                r_acc <= w_acc_sum[WIDTH-1:0];
                r_pwm <= w_acc_sum[WIDTH];
            end
        end
    end

    assign pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/audio_mix_dsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_mix_dsm                                                    |
// | Per-channel gain/mute, serial saturating mixer, delta-sigma out. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module audio_mix_dsm
    import audio_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int CHANNELS  = 4,
    parameter int GAIN_BITS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS*WIDTH-1:0]     sample,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic [CHANNELS*GAIN_BITS-1:0] gain,
    input  logic [CHANNELS-1:0]           mute,
    input  logic                          order,
    output logic                          clip,
    output logic                          pwm
);

    localparam int c_sum_w = sum_width(WIDTH, CHANNELS);
    localparam int c_idx_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(CHANNELS - 1);

    mix_state_t                   r_state;
    mix_state_t                   w_state_next;
    logic [CHANNELS*WIDTH-1:0]    r_frame;
    logic [CHANNELS*GAIN_BITS-1:0] r_gain;
    logic [CHANNELS-1:0]          r_mute;
    logic [c_idx_w-1:0]           r_idx;
    logic signed [c_sum_w-1:0]    r_sum;
    logic signed [WIDTH-1:0]      r_mix;

    logic [WIDTH-1:0]             w_chan;
    logic [GAIN_BITS-1:0]         w_shift;
    logic signed [WIDTH-1:0]      w_shifted;
    logic signed [c_sum_w-1:0]    w_term;
    logic signed [63:0]           w_sum64;

    assign w_chan    = r_frame[32'(r_idx) * WIDTH +: WIDTH];
    assign w_shift   = r_gain[32'(r_idx) * GAIN_BITS +: GAIN_BITS];
    assign w_shifted = $signed(w_chan) >>> w_shift;
    assign w_term    = r_mute[r_idx] ? '0
                     : {{(c_sum_w-WIDTH){w_shifted[WIDTH-1]}}, w_shifted};
    assign w_sum64   = {{(64-c_sum_w){r_sum[c_sum_w-1]}}, r_sum};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (sample_valid) w_state_next = MIX;
            MIX:     if (r_idx == c_last_idx) w_state_next = LOAD;
            LOAD:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_gain  <= '0;
            r_mute  <= '0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_mix   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (sample_valid) begin
                        r_frame <= sample;
                        r_gain  <= gain;
                        r_mute  <= mute;
                        r_sum   <= '0;
                        r_idx   <= '0;
                    end
                end
                MIX: begin
                    r_sum <= r_sum + w_term;
                    r_idx <= r_idx + c_idx_w'(1);
                end
                LOAD:    r_mix <= WIDTH'(saturate(w_sum64, WIDTH));
                default: ;
            endcase
        end
    end

    assign sample_ready = (r_state == IDLE);
    // The final sum is stable throughout LOAD, so clip can be decoded directly.
    assign clip = (r_state == LOAD) && (saturate(w_sum64, WIDTH) != w_sum64);

    audio_dsm_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .mix   (r_mix),
        .order (order),
        .pwm   (pwm)
    );

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_dsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_audio_mix_dsm                                                 |
// | Self-checking bench: directed and random frames vs a model.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_audio_mix_dsm;

    localparam int W = 12;
    localparam int C = 4;
    localparam int G = 2;
    localparam int FULL = 1 << W;

    logic             clk = 1'b0;
    logic             reset;
    logic [C*W-1:0]   sample;
    logic             sample_valid;
    logic             sample_ready;
    logic [C*G-1:0]   gain;
    logic [C-1:0]     mute;
    logic             order;
    logic             clip;
    logic             pwm;

    int n_tests = 0;
    int n_fail  = 0;

    audio_mix_dsm #(.WIDTH(W), .CHANNELS(C), .GAIN_BITS(G)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .gain         (gain),
        .mute         (mute),
        .order        (order),
        .clip         (clip),
        .pwm          (pwm)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact mixing arithmetic: floor division by 2^gain, unbounded integer sum.
    function automatic int model_sum(input logic [C*W-1:0] s, input logic [C*G-1:0] g,
                                     input logic [C-1:0] m);
        int total;
        total = 0;
        for (int k = 0; k < C; k++) begin
            logic [W-1:0] raw;
            int v, d, q;
            raw = s[k*W +: W];
            v = int'(raw);
            if (raw[W-1]) v = v - FULL;
            d = 1 << g[k*G +: G];
            q = v / d;
            if ((v % d) != 0 && v < 0) q = q - 1;
            if (!m[k]) total += q;
        end
        return total;
    endfunction

    function automatic int clamp(input int v);
        if (v > FULL/2 - 1) return FULL/2 - 1;
        if (v < -FULL/2) return -FULL/2;
        return v;
    endfunction

    // Handshakes one frame in; returns at the first ready cycle after it.
    task automatic send_frame(input logic [C*W-1:0] s, input logic [C*G-1:0] g,
                              input logic [C-1:0] m, output int low_cycles,
                              output int clip_count, output int clip_at);
        int guard;
        sample = s; gain = g; mute = m; sample_valid = 1'b1;
        guard = 0;
        while (!sample_ready && guard < 50) begin tick(); guard++; end
        tick();
        sample_valid = 1'b0;
        low_cycles = 0; clip_count = 0; clip_at = -1;
        for (int cyc = 1; cyc < 50 && !sample_ready; cyc++) begin
            low_cycles++;
            if (clip) begin clip_count++; clip_at = cyc; end
            tick();
        end
        if (clip) clip_count++;
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin tick(); if (pwm) ones++; end
    endtask

    task automatic test_reset();
        reset = 1'b1; sample_valid = 1'b0; sample = '0; gain = '0; mute = '0; order = 1'b0;
        repeat (3) tick();
        n_tests++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
        n_tests++; if (clip !== 1'b0) begin n_fail++; $display("FAIL reset_clip: got %b want 0", clip); end
        n_tests++; if (pwm !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0", pwm); end
        n_tests++; if (dut.r_mix !== 12'h000) begin n_fail++; $display("FAIL reset_mix: got %h want 000", dut.r_mix); end
        reset = 1'b0;
    endtask

    task automatic test_zero_frame();
        int low, nclip, at, ones, breaks;
        logic prev;
        send_frame('0, '0, '0, low, nclip, at);
        n_tests++; if (low != C + 1) begin n_fail++; $display("FAIL zero_ready_low: got %0d cycles want %0d", low, C + 1); end
        tick();
        prev = pwm; ones = 0; breaks = 0;
        for (int i = 0; i < FULL; i++) begin
            tick();
            if (pwm) ones++;
            if (pwm == prev) breaks++;
            prev = pwm;
        end
        n_tests++; if (ones != FULL/2) begin n_fail++; $display("FAIL zero_duty: got %0d ones want %0d", ones, FULL/2); end
        n_tests++; if (breaks != 0) begin n_fail++; $display("FAIL zero_alternate: got %0d repeats want 0", breaks); end
    endtask

    task automatic test_full_scale();
        int low, nclip, at, ones;
        send_frame({36'h0, 12'h7FF}, '0, 4'b1110, low, nclip, at);
        n_tests++; if (dut.r_mix !== 12'h7FF) begin n_fail++; $display("FAIL full_mix: got %h want 7ff", dut.r_mix); end
        n_tests++; if (nclip != 0) begin n_fail++; $display("FAIL full_clip: got %0d pulses want 0", nclip); end
        tick();
        count_ones(FULL, ones);
        n_tests++; if (ones != FULL - 1) begin n_fail++; $display("FAIL full_duty: got %0d ones want %0d", ones, FULL - 1); end
    endtask

    task automatic test_saturation();
        int low, nclip, at;
        send_frame({4{12'h7FF}}, '0, '0, low, nclip, at);
        n_tests++; if (dut.r_mix !== 12'h7FF) begin n_fail++; $display("FAIL satpos_mix: got %h want 7ff", dut.r_mix); end
        n_tests++; if (nclip != 1 || at != C + 1) begin n_fail++; $display("FAIL satpos_clip: got %0d pulses at %0d want 1 at %0d", nclip, at, C + 1); end
        send_frame({4{12'h800}}, '0, '0, low, nclip, at);
        n_tests++; if (dut.r_mix !== 12'h800) begin n_fail++; $display("FAIL satneg_mix: got %h want 800", dut.r_mix); end
        n_tests++; if (nclip != 1 || at != C + 1) begin n_fail++; $display("FAIL satneg_clip: got %0d pulses at %0d want 1 at %0d", nclip, at, C + 1); end
    endtask

    task automatic test_gain();
        int low, nclip, at;
        send_frame({24'h0, 12'hC00, 12'h400}, 8'b0000_0110, 4'b1100, low, nclip, at);
        n_tests++; if (dut.r_mix !== 12'hF00) begin n_fail++; $display("FAIL gain_mix: got %h want f00", dut.r_mix); end
        n_tests++; if (nclip != 0) begin n_fail++; $display("FAIL gain_clip: got %0d pulses want 0", nclip); end
    endtask

    task automatic test_random();
        int low, nclip, at, total, want_clip, ones;
        logic [C*W-1:0] s;
        logic [C*G-1:0] g;
        logic [C-1:0]   m;
        logic [W-1:0]   want;
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < C; k++) begin
                s[k*W +: W] = W'($urandom_range(0, FULL - 1));
                g[k*G +: G] = G'($urandom_range(0, (1 << G) - 1));
                m[k] = ($urandom_range(0, 3) == 0);
            end
            total = model_sum(s, g, m);
            want = W'(clamp(total));
            want_clip = (total != clamp(total)) ? 1 : 0;
            send_frame(s, g, m, low, nclip, at);
            n_tests++; if (dut.r_mix !== want) begin n_fail++; $display("FAIL rand_mix[%0d]: got %h want %h", f, dut.r_mix, want); end
            n_tests++; if (nclip != want_clip || (want_clip == 1 && at != C + 1)) begin
                n_fail++; $display("FAIL rand_clip[%0d]: got %0d pulses at %0d want %0d", f, nclip, at, want_clip); end
            n_tests++; if (low != C + 1) begin n_fail++; $display("FAIL rand_ready_low[%0d]: got %0d want %0d", f, low, C + 1); end
            if (f < 2) begin
                tick();
                count_ones(FULL, ones);
                n_tests++; if (ones != clamp(total) + FULL/2) begin
                    n_fail++; $display("FAIL rand_duty[%0d]: got %0d ones want %0d", f, ones, clamp(total) + FULL/2); end
            end
        end
    endtask

    task automatic test_order2();
        int low, nclip, at, ones, sat_hits, guard;
        order = 1'b1;
        send_frame({36'h0, 12'h400}, '0, 4'b1110, low, nclip, at);
        repeat (300) tick();
        ones = 0; sat_hits = 0;
        for (int i = 0; i < FULL; i++) begin
            tick();
            if (pwm) ones++;
            if (dut.u_core.r_i2 >= (1 << (W + 3)) - 1 || dut.u_core.r_i2 <= -(1 << (W + 3))) sat_hits++;
            if (dut.u_core.r_i1 >= (1 << (W + 1)) - 1 || dut.u_core.r_i1 <= -(1 << (W + 1))) sat_hits++;
        end
        n_tests++; if (ones < 3068 || ones > 3076) begin n_fail++; $display("FAIL order2_duty: got %0d ones want 3072+/-4", ones); end
        n_tests++; if (sat_hits != 0) begin n_fail++; $display("FAIL order2_range: got %0d saturated samples want 0", sat_hits); end
        guard = 0;
        while (!pwm && guard < 20) begin tick(); guard++; end
        order = 1'b0;
        tick();
        n_tests++; if (pwm !== 1'b0 || dut.u_core.r_i1 !== '0 || dut.u_core.r_i2 !== '0) begin
            n_fail++; $display("FAIL order_switch_to1: got pwm=%b i1=%0d i2=%0d want 0", pwm, dut.u_core.r_i1, dut.u_core.r_i2); end
        guard = 0;
        repeat (3) tick();
        while (!pwm && guard < 20) begin tick(); guard++; end
        order = 1'b1;
        tick();
        n_tests++; if (pwm !== 1'b0 || dut.u_core.r_acc !== '0) begin
            n_fail++; $display("FAIL order_switch_to2: got pwm=%b acc=%0d want 0", pwm, dut.u_core.r_acc); end
        order = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int guard, gap;
        sample = {4{12'h100}}; gain = '0; mute = '0; sample_valid = 1'b1;
        guard = 0;
        while (!sample_ready && guard < 50) begin tick(); guard++; end
        tick();
        sample = {4{12'h020}};
        gap = 1;
        while (!sample_ready && gap < 50) begin tick(); gap++; end
        n_tests++; if (dut.r_mix !== 12'h400) begin n_fail++; $display("FAIL b2b_first_mix: got %h want 400", dut.r_mix); end
        n_tests++; if (gap != C + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles want %0d", gap, C + 2); end
        tick();
        sample_valid = 1'b0;
        guard = 0;
        while (!sample_ready && guard < 50) begin tick(); guard++; end
        n_tests++; if (dut.r_mix !== 12'h080) begin n_fail++; $display("FAIL b2b_second_mix: got %h want 080", dut.r_mix); end
    endtask

    task automatic test_reset_mid();
        int guard;
        sample = {4{12'h050}}; gain = '0; mute = '0; sample_valid = 1'b1;
        guard = 0;
        while (!sample_ready && guard < 50) begin tick(); guard++; end
        tick();
        sample_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", sample_ready); end
        n_tests++; if (dut.r_mix !== 12'h000) begin n_fail++; $display("FAIL midreset_mix: got %h want 000", dut.r_mix); end
        n_tests++; if (pwm !== 1'b0) begin n_fail++; $display("FAIL midreset_pwm: got %b want 0", pwm); end
        repeat (C + 3) tick();
        n_tests++; if (dut.r_mix !== 12'h000) begin n_fail++; $display("FAIL midreset_discard: got %h want 000", dut.r_mix); end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_full_scale();
        test_saturation();
        test_gain();
        test_random();
        test_order2();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
